multiport_ram: RTL and testbench

Parametrised RAM with `nwr` independent write ports and one registered read port. It is the next generation of the single-write-port `width`/`widthad` RAM. It adds deterministic priority between simultaneously writing ports, a selectable read-during-write mode, collision reporting, and a post-reset clear sequencer that zeroes every entry. It serves as shared state storage written by several pipeline stages and read by one consumer.

---
 rtl/multiport_ram.sv | 127 ++++++++++++
 tb/tb_multiport_ram.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_ram.sv
// Purpose: RAM with nwr write ports (lowest index wins on a shared address) and one registered read port.
// Latency: writes 1 edge, reads 1 edge (q/q_valid), collision flag/count 1 edge; post-reset clear takes 2**widthad edges.
// Backpressure: none; requests are accepted on every RUN edge and ignored while init_busy is high.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wren[nwr]                  per-port write enable
//   wraddress[nwr*widthad]     port i address at [i*widthad +: widthad]
//   data[nwr*width]            port i data at [i*width +: width]
//   rden, rdaddress            read request and address
//   q, q_valid                 registered read data, one-cycle valid per accepted read
//   init_busy                  clear sequence in progress
//   collision, collision_count one-cycle same-address write pulse, saturating cycle count
module multiport_ram #(
  parameter int width    = 8,
  parameter int widthad  = 4,
  parameter int nwr      = 2,
  parameter int rdw_mode = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [nwr-1:0]           wren,
  input  logic [nwr*widthad-1:0]   wraddress,
  input  logic [nwr*width-1:0]     data,
  input  logic                     rden,
  input  logic [widthad-1:0]       rdaddress,
  output logic [width-1:0]         q,
  output logic                     q_valid,
  output logic                     init_busy,
  output logic                     collision,
  output logic [15:0]              collision_count
);

  localparam int depth = 2 ** widthad;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t             state, state_nxt;
  logic [widthad-1:0] ptr;
  logic [width-1:0]   mem [depth];

  logic [widthad-1:0] wa [nwr];
  logic [width-1:0]   wd [nwr];
  logic [nwr-1:0]     win;
  logic               coll_any;
  logic [width-1:0]   rd_val;
  logic               run;

  assign run       = (state == RUN);
  assign init_busy = (state == CLEAR);

  // A port wins its address unless a lower-indexed enabled port targets the
  // same address. Any enabled port that loses means the cycle collided.
  always_comb begin
    win      = '0;
    coll_any = 1'b0;
    for (int i = 0; i < nwr; i++) begin
      wa[i] = wraddress[i*widthad +: widthad];
      wd[i] = data[i*width +: width];
    end
    for (int i = 0; i < nwr; i++) begin
      win[i] = wren[i];
      for (int j = 0; j < i; j++) begin
        if (wren[j] && (wa[j] == wa[i])) win[i] = 1'b0;
      end
      if (wren[i] && !win[i]) coll_any = 1'b1;
    end
  end

  // Read data: array contents are the pre-write value; in new-data mode the
  // winning write to the same address is forwarded instead.
  always_comb begin
    rd_val = mem[rdaddress];
    if (rdw_mode != 0) begin
      for (int i = 0; i < nwr; i++) begin
        if (win[i] && (wa[i] == rdaddress)) rd_val = wd[i];
      end
    end
  end

  // Next-state logic: CLEAR leaves on the edge that clears the last entry.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (ptr == {widthad{1'b1}}) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) ptr <= ptr + 1'b1;
    end
  end

  // Storage has no reset; the clear sequence zeroes it before first use.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else begin
      for (int i = 0; i < nwr; i++) begin
        if (win[i]) mem[wa[i]] <= wd[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q               <= '0;
      q_valid         <= 1'b0;
      collision       <= 1'b0;
      collision_count <= '0;
    end else begin
      q_valid   <= run && rden;
      collision <= run && coll_any;
      if (run && rden) q <= rd_val;
      if (run && coll_any && (collision_count != 16'hFFFF))
        collision_count <= collision_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_multiport_ram.sv
// Purpose: self-checking bench for multiport_ram, two instances (old-data and new-data read-during-write).
// Latency: model predicts outputs one edge after inputs; outputs compared on every falling edge.
// Backpressure: not applicable; stimulus is directed plus randomized.
module tb_multiport_ram;

  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int NWR   = 3;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NWR-1:0]    wren;
  logic [NWR*AW-1:0] wraddress;
  logic [NWR*W-1:0]  data;
  logic              rden;
  logic [AW-1:0]     rdaddress;

  logic [W-1:0] q0, q1;
  logic         qv0, qv1, busy0, busy1, coll0, coll1;
  logic [15:0]  cnt0, cnt1;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  multiport_ram #(.width(W), .widthad(AW), .nwr(NWR), .rdw_mode(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wren(wren), .wraddress(wraddress), .data(data),
    .rden(rden), .rdaddress(rdaddress), .q(q0), .q_valid(qv0), .init_busy(busy0),
    .collision(coll0), .collision_count(cnt0)
  );

  multiport_ram #(.width(W), .widthad(AW), .nwr(NWR), .rdw_mode(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wren(wren), .wraddress(wraddress), .data(data),
    .rden(rden), .rdaddress(rdaddress), .q(q1), .q_valid(qv1), .init_busy(busy1),
    .collision(coll1), .collision_count(cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_mem [DEPTH];
  logic [W-1:0] m_pre [DEPTH];
  bit           m_seen [DEPTH];
  int           m_clr;
  bit           m_coll;
  int           ma;
  logic [W-1:0] e_q0, e_q1;
  logic         e_qv, e_busy, e_coll;
  logic [15:0]  e_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q0 = '0; e_q1 = '0; e_qv = 0; e_busy = 1; e_coll = 0; e_cnt = '0;
      m_clr = 0;
      // The clear sequence guarantees all-zero contents before any access.
      for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    end else if (m_clr < DEPTH) begin
      m_clr++;
      e_qv   = 0;
      e_coll = 0;
      e_busy = (m_clr < DEPTH);
    end else begin
      m_pre  = m_mem;
      m_coll = 0;
      for (int a = 0; a < DEPTH; a++) m_seen[a] = 0;
      // First (lowest-index) writer to an address takes it; later ones collide.
      for (int p = 0; p < NWR; p++) begin
        if (wren[p]) begin
          ma = int'(wraddress[p*AW +: AW]);
          if (m_seen[ma]) m_coll = 1;
          else begin
            m_seen[ma] = 1;
            m_mem[ma]  = data[p*W +: W];
          end
        end
      end
      e_coll = m_coll;
      if (m_coll && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
      e_qv = rden;
      if (rden) begin
        e_q0 = m_pre[rdaddress];
        e_q1 = m_mem[rdaddress];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("q_old_mode", q0, e_q0);
      check("q_new_mode", q1, e_q1);
      check("q_valid0", qv0, e_qv);
      check("q_valid1", qv1, e_qv);
      check("init_busy", busy0, e_busy);
      check("collision", coll0, e_coll);
      check("collision_count", cnt0, e_cnt);
      check("collision_count1", cnt1, e_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    wren = '0;
    rden = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
    wren[p]              = 1'b1;
    wraddress[p*AW +: AW] = a;
    data[p*W +: W]       = d;
  endtask

  task automatic rd_check(input string name, input logic [AW-1:0] a,
                          input logic [W-1:0] exp0, input logic [W-1:0] exp1);
    idle();
    rden      = 1'b1;
    rdaddress = a;
    tick();
    check({name, "_old"}, q0, exp0);
    check({name, "_new"}, q1, exp1);
    check({name, "_vld"}, qv0, 1'b1);
    idle();
  endtask

  task automatic count_clear(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (!busy0) break;
    end
    check(name, n, 16);
  endtask

  initial begin
    rst_n = 1'b1; idle(); wraddress = '0; data = '0; rdaddress = '0;
    #2 rst_n = 1'b0;
    #1 chk_en = 1;
    check("reset_busy", busy0, 1'b1);
    check("reset_q", q0, 8'h00);
    #20;
    @(negedge clk);
    // Requests during CLEAR must be ignored.
    wr(0, 4'd9, 8'hAA);
    rden = 1'b1; rdaddress = 4'd9;
    rst_n = 1'b1;
    count_clear("clear_edges");
    tick();
    idle();
    for (int a = 0; a < DEPTH; a++) rd_check("clear_zero", a[AW-1:0], 8'h00, 8'h00);
    rd_check("clear_write_ignored", 4'd9, 8'h00, 8'h00);

    // Parallel writes to distinct addresses.
    wr(0, 4'd3, 8'h11); wr(1, 4'd5, 8'h22);
    tick();
    check("parallel_no_coll", coll0, 1'b0);
    idle();
    rd_check("parallel_a3", 4'd3, 8'h11, 8'h11);
    rd_check("parallel_a5", 4'd5, 8'h22, 8'h22);

    // Three-way collision on one address: port 0 wins.
    wr(0, 4'd7, 8'hA0); wr(1, 4'd7, 8'hA1); wr(2, 4'd7, 8'hA2);
    tick();
    check("prio_coll_pulse", coll0, 1'b1);
    check("prio_coll_count", cnt0, 16'd1);
    idle();
    tick();
    check("prio_coll_drop", coll0, 1'b0);
    rd_check("prio_a7", 4'd7, 8'hA0, 8'hA0);

    // Read-during-write on the same address.
    wr(0, 4'd2, 8'h55);
    tick();
    idle();
    wr(0, 4'd2, 8'h66); rden = 1'b1; rdaddress = 4'd2;
    tick();
    check("rdw_old", q0, 8'h55);
    check("rdw_new", q1, 8'h66);
    idle();
    rd_check("rdw_after", 4'd2, 8'h66, 8'h66);

    // Randomized traffic, address range narrowed half the time to provoke collisions.
    for (int c = 0; c < 2000; c++) begin
      idle();
      wren = NWR'($urandom);
      for (int p = 0; p < NWR; p++) begin
        wraddress[p*AW +: AW] = (c % 2 == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH-1));
        data[p*W +: W]        = W'($urandom);
      end
      rden      = 1'($urandom);
      rdaddress = AW'($urandom_range(0, DEPTH-1));
      tick();
    end

    // Saturate the collision counter.
    idle();
    wr(0, 4'd1, 8'h5A); wr(1, 4'd1, 8'h3C);
    for (int c = 0; c < 65540; c++) tick();
    check("sat_count", cnt0, 16'hFFFF);
    idle();
    rden = 1'b1; rdaddress = 4'd1;
    tick();
    check("pre_reset_q", q0, 8'h5A);
    check("pre_reset_qv", qv0, 1'b1);
    // Asynchronous reset mid-cycle with a read still requested.
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_q", q0, 8'h00);
    check("mid_reset_qv", qv0, 1'b0);
    check("mid_reset_count", cnt0, 16'h0000);
    check("mid_reset_coll", coll0, 1'b0);
    check("mid_reset_busy", busy0, 1'b1);
    #30;
    @(negedge clk);
    rst_n = 1'b1;
    count_clear("reclear_edges");
    tick();
    idle();
    rd_check("reclear_a1", 4'd1, 8'h00, 8'h00);
    rd_check("reclear_a7", 4'd7, 8'h00, 8'h00);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
